mult_seq_ctrl: RTL
==================

MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 15, max cycles in WAIT for mult_done before abort (legal range 6..255).
REQ-002 SHALL have port: clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have port: reset_a  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  operand pair offered.
REQ-005 SHALL have port: in_ready  output  1  operand pair accepted when in_valid&in_ready.
REQ-006 SHALL have ports: in_a, in_b  input  8 each  operands.
REQ-007 SHALL have ports: mult_dataa, mult_datab  output  8 each  operands held to the downstream 8x8 multiplier.
REQ-008 SHALL have port: mult_start  output  1  start pulse to multiplier.
REQ-009 SHALL have ports: mult_done  input  1  multiplier done flag; mult_product  input  16  multiplier result.
REQ-010 SHALL have ports: out_valid  output  1; out_ready  input  1; out_product  output  16; out_err  output  1  result handshake.

Function
REQ-011 SHALL implement FSM states IDLE, LAUNCH, WAIT, HOLD.
REQ-012 IDLE: in_ready=1; on in_valid, register in_a/in_b into mult_dataa/mult_datab and go to LAUNCH.
REQ-013 LAUNCH: mult_start=1 for exactly one cycle; next state WAIT unconditionally.
REQ-014 WAIT: mult_start=0; on mult_done=1, capture mult_product into out_product, out_err=0, go to HOLD.
REQ-015 Nominal latency: mult_done sampled 5 cycles after the LAUNCH cycle; result valid (out_valid=1) on the following cycle.
REQ-016 mult_dataa/mult_datab SHALL stay constant from LAUNCH until leaving HOLD.
REQ-017 HOLD: out_valid=1, out_product/out_err stable; on out_ready=1, go to IDLE next cycle.
REQ-018 in_ready SHALL be 0 in every state except IDLE; HOLD→IDLE and new acceptance never occur in the same cycle.
REQ-019 mult_done in IDLE, LAUNCH or HOLD SHALL be ignored.
REQ-020 mult_start SHALL never be high outside LAUNCH.

Reset
REQ-021 On reset_a=1 at a clock edge: state=IDLE, mult_start=0, mult_dataa=mult_datab=0, out_valid=0, out_product=0, out_err=0, timeout counter=0.
REQ-022 Reset mid-operation (any state) SHALL discard the in-flight operation with no result emitted.

Configuration
REQ-023 Macro MULT_SEQ_TIMEOUT_EN defined: WAIT counts cycles; if count reaches TIMEOUT_CYCLES with no mult_done, go to HOLD with out_product=0, out_err=1; counter clears on entering WAIT.
REQ-024 MULT_SEQ_TIMEOUT_EN undefined: no counter logic; WAIT persists until mult_done; out_err tied 0.
REQ-025 mult_done and timeout in the same cycle: mult_done wins (out_err=0).

Structure
REQ-026 Shared package mult_seq_pkg SHALL hold the state enum, operand width (8), product width (16), and TIMEOUT_CYCLES default.
REQ-027 Timeout counter SHALL be a sub-module mult_seq_timer (clear, enable, expired), instantiated only under MULT_SEQ_TIMEOUT_EN.

Verification
REQ-028 in_a=0xFF, in_b=0xFF, out_ready=1, with real multiplier -> one-cycle mult_start, out_valid after 6 cycles, out_product=0xFE01, out_err=0.
REQ-029 in_a=0x17, in_b=0x32 (sums after 0xFF+24, 0xFF+51 wrap) then in_a=0x18, in_b=0x33 back-to-back, out_ready=1 -> 0x047E then 0x04C8; in_ready low between.
REQ-030 out_ready held 0 for 10 cycles in HOLD -> out_valid/out_product stable, in_ready=0, no second mult_start.
REQ-031 MULT_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8, mult_done forced 0 -> HOLD after 8 WAIT cycles, out_err=1, out_product=0x0000.
REQ-032 reset_a=1 for one cycle during WAIT -> next cycle IDLE, all outputs at reset values, no out_valid; later operation 0x02*0x03 returns 0x0006.
REQ-033 Spurious mult_done pulse in IDLE -> no state change, out_valid stays 0.

Source files
------------

// File: rtl/mult_seq_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier controller.
package mult_seq_pkg;

    localparam int unsigned OpWidth              = 8;
    localparam int unsigned ProdWidth            = 16;
    localparam int unsigned TimeoutCyclesDefault = 15;

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StWait,
        StHold
    } state_e;

endpackage

// File: rtl/mult_seq_timer.sv
// WAIT-state cycle counter; expired is raised on the Limit-th enabled cycle after a clear.
module mult_seq_timer #(
    parameter int unsigned Limit = 15
) (
    input  logic clk,
    input  logic reset_a,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] LastCount = 8'(Limit - 1);

    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end
    end

    assign expired = enable && (count_q == LastCount);

    always_ff @(posedge clk) begin
        if (reset_a) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Handshaked sequencer for an external 8x8 multiplier: accept, launch, wait for done, hold result.
// Optional WAIT timeout enabled by defining MULT_SEQ_TIMEOUT_EN.
module mult_seq_ctrl
    import mult_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDefault
) (
    input  logic                 clk,
    input  logic                 reset_a,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OpWidth-1:0]   in_a,
    input  logic [OpWidth-1:0]   in_b,
    output logic [OpWidth-1:0]   mult_dataa,
    output logic [OpWidth-1:0]   mult_datab,
    output logic                 mult_start,
    input  logic                 mult_done,
    input  logic [ProdWidth-1:0] mult_product,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ProdWidth-1:0] out_product,
    output logic                 out_err
);

    if (TIMEOUT_CYCLES < 6 || TIMEOUT_CYCLES > 255) begin : gen_param_check
        $error("TIMEOUT_CYCLES must be within 6..255");
    end

    state_e               state_q, state_d;
    logic [OpWidth-1:0]   a_q, a_d, b_q, b_d;
    logic [ProdWidth-1:0] prod_q, prod_d;
    logic                 err_q, err_d;
    logic                 timeout;

`ifdef MULT_SEQ_TIMEOUT_EN
    mult_seq_timer #(
        .Limit (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset_a (reset_a),
        .clear   (state_q == StLaunch),
        .enable  (state_q == StWait),
        .expired (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    state_d = StLaunch;
                end
            end
            StLaunch: state_d = StWait;
            StWait: begin
                // A done arriving on the timeout cycle still counts as success.
                if (mult_done) begin
                    prod_d  = mult_product;
                    err_d   = 1'b0;
                    state_d = StHold;
                end else if (timeout) begin
                    prod_d  = '0;
                    err_d   = 1'b1;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_a) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
            err_q   <= err_d;
        end
    end

    assign in_ready    = (state_q == StIdle);
    assign mult_start  = (state_q == StLaunch);
    assign out_valid   = (state_q == StHold);
    assign mult_dataa  = a_q;
    assign mult_datab  = b_q;
    assign out_product = prod_q;
    assign out_err     = err_q;

endmodule
